mem_wb_writeback: RTL

Memory-to-writeback pipeline stage of the MIPS core: the writer-side counterpart of the register file. It registers the MEM-stage result and drives the register file write port (`we`/`rw`/`wdata`). It also returns forwarded operand data to the ID-stage read ports so a same-cycle write is never missed. A retired-instruction counter is kept for debug and performance.

---
 rtl/mem_wb_writeback_pkg.sv | 47 ++++
 rtl/wb_fwd_mux.sv | 35 +++
 rtl/mem_wb_writeback.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mem_wb_writeback_pkg.sv
// ============================================================================
// Module : mem_wb_writeback_pkg
// Brief  : Shared core defines plus the writeback holding-register update rule.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_wb_writeback_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int DATA_WIDTH     = 32;

    typedef logic [REG_ADDR_WIDTH-1:0] RegAddrBus;
    typedef logic [DATA_WIDTH-1:0]     RegBus;

    localparam RegBus     ZeroWord     = 32'h0;
    localparam RegAddrBus NOPRegAddr   = 5'h0;
    localparam logic      WriteEnable  = 1'b1;
    localparam logic      WriteDisable = 1'b0;
    localparam logic      ReadEnable   = 1'b1;
    localparam logic      ReadDisable  = 1'b0;

    typedef enum logic [1:0] {
        WB_CAPTURE = 2'd0,
        WB_BUBBLE  = 2'd1,
        WB_HOLD    = 2'd2
    } wb_action_e;

    // stall_mem=0 with stall_wb=1 is not produced by ctrl; it falls through to capture.
    function automatic wb_action_e wb_action(input logic flush,
                                             input logic stall_mem,
                                             input logic stall_wb);
        wb_action_e act;
        if (flush)
            act = WB_BUBBLE;
        else if (stall_mem && !stall_wb)
            act = WB_BUBBLE;
        else if (stall_mem)
            act = WB_HOLD;
        else
            act = WB_CAPTURE;
        return act;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_fwd_mux.sv
// ============================================================================
// Module : wb_fwd_mux
// Brief  : Per-port operand selector returning pending writeback data to ID.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_fwd_mux
    import mem_wb_writeback_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32
) (
    input  logic                  rd_en_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0]     rf_rdata_i,
    input  logic                  we_i,
    input  logic [REG_ADDR_W-1:0] rw_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     fwd_rdata_o
);

    always_comb begin
        fwd_rdata_o = rf_rdata_i;
        if (rd_en_i == ReadDisable)
            fwd_rdata_o = '0;
        else if (rd_addr_i == '0)
            fwd_rdata_o = '0;
        else if ((we_i == WriteEnable) && (rw_i == rd_addr_i))
            fwd_rdata_o = wdata_i;
    end

endmodule

`default_nettype wire

// File: rtl/mem_wb_writeback.sv
// ============================================================================
// Module : mem_wb_writeback
// Brief  : MEM->WB holding register, GPR write port, ID forwarding, retire count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_wb_writeback
    import mem_wb_writeback_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    input  logic                  mem_wreg,
    input  logic [REG_ADDR_W-1:0] mem_wd,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic                  stall_mem,
    input  logic                  stall_wb,
    input  logic                  flush,
    input  logic                  rd1_en,
    input  logic                  rd2_en,
    input  logic [REG_ADDR_W-1:0] rd1_addr,
    input  logic [REG_ADDR_W-1:0] rd2_addr,
    input  logic [DATA_W-1:0]     rf_rdata1,
    input  logic [DATA_W-1:0]     rf_rdata2,
    output logic                  we,
    output logic [REG_ADDR_W-1:0] rw,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     fwd_rdata1,
    output logic [DATA_W-1:0]     fwd_rdata2,
    output logic [31:0]           retire_cnt
);

    logic                  wb_valid_q, wb_valid_d;
    logic                  wb_wreg_q,  wb_wreg_d;
    logic [REG_ADDR_W-1:0] wb_wd_q,    wb_wd_d;
    logic [DATA_W-1:0]     wb_wdata_q, wb_wdata_d;
    logic [31:0]           retire_cnt_q, retire_cnt_d;

    wb_action_e w_action;
    logic       w_retire;

    assign w_action = wb_action(flush, stall_mem, stall_wb);
    assign w_retire = (w_action == WB_CAPTURE) && mem_valid;

    always_comb begin
        wb_valid_d   = wb_valid_q;
        wb_wreg_d    = wb_wreg_q;
        wb_wd_d      = wb_wd_q;
        wb_wdata_d   = wb_wdata_q;
        retire_cnt_d = retire_cnt_q + {31'd0, w_retire};
        case (w_action)
            WB_CAPTURE: begin
                wb_valid_d = mem_valid;
                wb_wreg_d  = mem_wreg;
                wb_wd_d    = mem_wd;
                wb_wdata_d = mem_wdata;
            end
            WB_BUBBLE: begin
                wb_valid_d = 1'b0;
                wb_wreg_d  = 1'b0;
                wb_wd_d    = '0;
                wb_wdata_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_q   <= 1'b0;
            wb_wreg_q    <= 1'b0;
            wb_wd_q      <= '0;
            wb_wdata_q   <= '0;
            retire_cnt_q <= 32'd0;
        end else begin
            wb_valid_q   <= wb_valid_d;
            wb_wreg_q    <= wb_wreg_d;
            wb_wd_q      <= wb_wd_d;
            wb_wdata_q   <= wb_wdata_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // A held entry keeps we asserted; rewriting the same value is harmless.
    assign we         = wb_valid_q && wb_wreg_q && (wb_wd_q != '0);
    assign rw         = wb_wd_q;
    assign wdata      = wb_wdata_q;
    assign retire_cnt = retire_cnt_q;

    wb_fwd_mux #(
        .REG_ADDR_W (REG_ADDR_W),
        .DATA_W     (DATA_W)
    ) u_fwd1 (
        .rd_en_i     (rd1_en),
        .rd_addr_i   (rd1_addr),
        .rf_rdata_i  (rf_rdata1),
        .we_i        (we),
        .rw_i        (rw),
        .wdata_i     (wdata),
        .fwd_rdata_o (fwd_rdata1)
    );

    wb_fwd_mux #(
        .REG_ADDR_W (REG_ADDR_W),
        .DATA_W     (DATA_W)
    ) u_fwd2 (
        .rd_en_i     (rd2_en),
        .rd_addr_i   (rd2_addr),
        .rf_rdata_i  (rf_rdata2),
        .we_i        (we),
        .rw_i        (rw),
        .wdata_i     (wdata),
        .fwd_rdata_o (fwd_rdata2)
    );

endmodule

`default_nettype wire
